// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and memory-stage state type.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane logic.
// Covers store strobes and replicated data, load extract and extend, and access legality.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misalign,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wstrb    = 4'b0000;
    wdata    = 32'h0;
    misalign = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          wstrb = 4'b0001 << offset;
          wdata = {4{data[7:0]}};
        end
        F3_H: begin
          wstrb    = 4'b0011 << {offset[1], 1'b0};
          wdata    = {2{data[15:0]}};
          misalign = offset[0];
        end
        F3_W: begin
          wstrb    = 4'b1111;
          wdata    = data;
          misalign = |offset;
        end
        default: misalign = 1'b1;
      endcase
    end else if (is_load) begin
      case (funct3)
        F3_B, F3_BU: misalign = 1'b0;
        F3_H, F3_HU: misalign = offset[0];
        F3_W:        misalign = |offset;
        default:     misalign = 1'b1;
      endcase
    end
  end

  assign ld_byte = rdata[{ld_offset, 3'b000} +: 8];
  assign ld_half = rdata[{ld_offset[1], 4'b0000} +: 16];

  always_comb begin
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: drives a req/ready data port for loads and stores.
// Passes ALU results straight to write-back and stalls upstream while a transaction is open.
module mem_access
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] result,
  input  logic [31:0] data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

  state_t      state;
  logic [31:0] to_cnt;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [4:0]  pend_rd;

  logic        is_load, is_store, is_mem, misalign;
  logic [3:0]  wstrb;
  logic [31:0] wdata, ld_data;

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = is_load || is_store;

  lsu_align u_align (
    .is_load   (is_load),
    .is_store  (is_store),
    .funct3    (funct3),
    .offset    (result[1:0]),
    .data      (data),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .misalign  (misalign),
    .ld_funct3 (ld_funct3),
    .ld_offset (ld_offset),
    .rdata     (mem_rdata),
    .ld_data   (ld_data)
  );

  // Faulting accesses retire next cycle without a bus cycle, so only legal ones stall.
  assign stall = (state == WAIT) ||
                 ((state == IDLE) && in_valid && is_mem && !misalign);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      to_cnt    <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'h0;
      mem_wdata <= 32'h0;
      ld_funct3 <= 3'h0;
      ld_offset <= 2'h0;
      pend_rd   <= 5'h0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 5'h0;
      wb_data   <= 32'h0;
      wb_err    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= 5'h0;
      wb_data  <= 32'h0;
      wb_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= (opcode != OPC_BRANCH);
              wb_rd    <= rd;
              wb_data  <= result;
            end else if (misalign) begin
              wb_valid <= 1'b1;
              wb_err   <= 1'b1;
              wb_rd    <= rd;
            end else begin
              state     <= WAIT;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {result[31:2], 2'b00};
              mem_wstrb <= wstrb;
              mem_wdata <= wdata;
              ld_funct3 <= funct3;
              ld_offset <= result[1:0];
              pend_rd   <= rd;
              to_cnt    <= 32'h0;
            end
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= pend_rd;
            if (!mem_we) begin
              wb_we   <= 1'b1;
              wb_data <= ld_data;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TIMEOUT_LAST)) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_err   <= 1'b1;
            wb_rd    <= pend_rd;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
